// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  localparam int          FETCH_DATA_WIDTH = 32;
  localparam logic [31:0] FETCH_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0] instruction;
    logic [FETCH_DATA_WIDTH-1:0] pc_plus4;
    logic                        valid;
  } if_id_t;

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Combinational fetch bus between the fetch stage and Program_Memory.
interface pc_fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] address_o;
  logic [DATA_WIDTH-1:0] instruction_i;

  modport master (output address_o, input  instruction_i);
  modport slave  (input  address_o, output instruction_i);
endinterface

// File: rtl/pc_fetch_stage_pc_register.sv
// Program counter: enable-gated register, asynchronous active-low reset to RESET_VAL.
module pc_register #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= RESET_VAL;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch: PC selection, word-address translation, range fault and IF/ID register.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = FETCH_DATA_WIDTH,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = FETCH_RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  branch_taken_i,
  input  logic [DATA_WIDTH-1:0] branch_target_i,
  input  logic                  jump_i,
  input  logic [DATA_WIDTH-1:0] jump_target_i,
  pc_fetch_stage_if.master      mem,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  addr_fault_o,
  output logic [DATA_WIDTH-1:0] if_id_instruction_o,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
  output logic                  if_id_valid_o
);

  logic [DATA_WIDTH-1:0] w_pc;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic                  w_pc_en;
  logic [DATA_WIDTH-1:0] w_offset;
  logic [DATA_WIDTH-1:0] w_word_idx;
  logic                  w_fault;
  if_id_t                r_if_id;
  if_id_t                w_if_id_next;

  assign w_pc_plus4 = w_pc + DATA_WIDTH'(4);

  // Redirects override a stall; targets are forced word-aligned before loading.
  always_comb begin
    w_pc_next = w_pc_plus4;
    w_pc_en   = 1'b1;
    if (jump_i)
      w_pc_next = {jump_target_i[DATA_WIDTH-1:2], 2'b00};
    else if (branch_taken_i)
      w_pc_next = {branch_target_i[DATA_WIDTH-1:2], 2'b00};
    else if (stall_i)
      w_pc_en   = 1'b0;
  end

  pc_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_VAL  (RESET_PC)
  ) u_pc_register (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_pc_en),
    .i_d   (w_pc_next),
    .o_q   (w_pc)
  );

  // Program_Memory is indexed in words relative to the reset PC.
  assign w_offset   = w_pc - RESET_PC;
  assign w_word_idx = w_offset >> 2;
  assign w_fault    = (w_pc < RESET_PC) || (w_word_idx >= DATA_WIDTH'(MEMORY_DEPTH));

  always_comb begin
    w_if_id_next = r_if_id;
    if (flush_i) begin
      w_if_id_next = '{instruction: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    end else if (!stall_i) begin
      if (w_fault)
        w_if_id_next = '{instruction: NOP_INSTR, pc_plus4: w_pc_plus4, valid: 1'b0};
      else
        w_if_id_next = '{instruction: mem.instruction_i, pc_plus4: w_pc_plus4, valid: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_if_id <= '{instruction: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    else        r_if_id <= w_if_id_next;
  end

  assign mem.address_o         = w_word_idx;
  assign pc_o                  = w_pc;
  assign pc_plus4_o            = w_pc_plus4;
  assign addr_fault_o          = w_fault;
  assign if_id_instruction_o   = r_if_id.instruction;
  assign if_id_pc_plus4_o      = r_if_id.pc_plus4;
  assign if_id_valid_o         = r_if_id.valid;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed plus randomized bench for pc_fetch_stage against a behavioural fetch model.
module tb_pc_fetch_stage;

  localparam logic [31:0] RST   = 32'h0040_0000;
  localparam int          DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, br = 1'b0, jp = 1'b0;
  logic [31:0] bt = '0, jt = '0;
  logic [31:0] pc_o, pc_plus4_o, ins_o, p4_o;
  logic        fault_o, vld_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ins, m_p4;
  logic        m_vld;

  pc_fetch_stage_if #(.DATA_WIDTH(32)) mif ();

  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    return (idx < DEPTH) ? (32'h1000_0000 + idx) : 32'hDEAD_BEEF;
  endfunction

  assign mif.instruction_i = rom_word(mif.address_o);

  pc_fetch_stage #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .RESET_PC(RST)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall_i             (stall),
    .flush_i             (flush),
    .branch_taken_i      (br),
    .branch_target_i     (bt),
    .jump_i              (jp),
    .jump_target_i       (jt),
    .mem                 (mif),
    .pc_o                (pc_o),
    .pc_plus4_o          (pc_plus4_o),
    .addr_fault_o        (fault_o),
    .if_id_instruction_o (ins_o),
    .if_id_pc_plus4_o    (p4_o),
    .if_id_valid_o       (vld_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_fault(input logic [31:0] pc);
    return (pc < RST) || (((pc - RST) >> 2) >= DEPTH);
  endfunction

  task automatic model_reset();
    m_pc = RST; m_ins = '0; m_p4 = '0; m_vld = 1'b0;
  endtask

  task automatic check_all(input string w);
    check({w, ".pc"},      pc_o,              m_pc);
    check({w, ".pc4"},     pc_plus4_o,        m_pc + 32'd4);
    check({w, ".addr"},    mif.address_o,     (m_pc - RST) >> 2);
    check({w, ".fault"},   {31'd0, fault_o},  {31'd0, m_fault(m_pc)});
    check({w, ".ifid_in"}, ins_o,             m_ins);
    check({w, ".ifid_p4"}, p4_o,              m_p4);
    check({w, ".ifid_v"},  {31'd0, vld_o},    {31'd0, m_vld});
  endtask

  // One clock: drive inputs, predict, clock, then compare everything.
  task automatic step(input string w, input logic s, input logic f, input logic b,
                      input logic j, input logic [31:0] btv, input logic [31:0] jtv);
    logic [31:0] n_pc, n_ins, n_p4;
    logic        n_vld;
    stall = s; flush = f; br = b; jp = j; bt = btv; jt = jtv;
    n_ins = m_ins; n_p4 = m_p4; n_vld = m_vld;
    if (f) begin
      n_ins = '0; n_p4 = '0; n_vld = 1'b0;
    end else if (!s) begin
      n_p4  = m_pc + 32'd4;
      n_vld = !m_fault(m_pc);
      n_ins = n_vld ? rom_word((m_pc - RST) / 4) : 32'd0;
    end
    if (j)      n_pc = jtv & ~32'd3;
    else if (b) n_pc = btv & ~32'd3;
    else if (s) n_pc = m_pc;
    else        n_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ins = n_ins; m_p4 = n_p4; m_vld = n_vld;
    check_all(w);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.pc_const", pc_o, 32'h0040_0000);
    reset = 1'b1;

    step("run1", 0, 0, 0, 0, '0, '0);
    check("run1.first_instr", ins_o, 32'h1000_0000);
    check("run1.first_valid", {31'd0, vld_o}, 32'd1);
    check("run1.pc_const", pc_o, 32'h0040_0004);
    step("run2", 0, 0, 0, 0, '0, '0);
    check("run2.pc_const", pc_o, 32'h0040_0008);
    check("run2.addr_const", mif.address_o, 32'd2);

    step("stall1", 1, 0, 0, 0, '0, '0);
    step("stall2", 1, 0, 0, 0, '0, '0);
    check("stall.pc_const", pc_o, 32'h0040_0008);
    check("stall.ifid_const", ins_o, 32'h1000_0001);
    step("resume", 0, 0, 0, 0, '0, '0);
    check("resume.pc_const", pc_o, 32'h0040_000C);
    step("run3", 0, 0, 0, 0, '0, '0);

    step("branch", 0, 0, 1, 0, 32'h0040_0040, '0);
    check("branch.pc_const", pc_o, 32'h0040_0040);
    check("branch.addr_const", mif.address_o, 32'd16);
    step("br_jmp", 0, 0, 1, 1, 32'h0040_0040, 32'h0040_0010);
    check("br_jmp.pc_const", pc_o, 32'h0040_0010);

    step("flush_stall", 1, 1, 0, 0, '0, '0);
    check("flush_stall.pc_const", pc_o, 32'h0040_0010);
    check("flush_stall.ins_const", ins_o, 32'h0);
    check("flush_stall.v_const", {31'd0, vld_o}, 32'd0);

    step("to_end", 0, 0, 0, 1, '0, 32'h0040_0080);
    check("to_end.fault_const", {31'd0, fault_o}, 32'd1);
    step("past_end", 0, 0, 0, 0, '0, '0);
    check("past_end.v_const", {31'd0, vld_o}, 32'd0);
    step("low_tgt", 0, 0, 0, 1, '0, 32'h0030_0000);
    check("low_tgt.fault_const", {31'd0, fault_o}, 32'd1);
    step("unaligned", 0, 0, 0, 1, '0, 32'h0040_0013);
    check("unaligned.pc_const", pc_o, 32'h0040_0010);
    step("wrap", 0, 0, 1, 0, 32'hFFFF_FFFE, '0);
    check("wrap.pc4_const", pc_plus4_o, 32'h0);
    step("wrap_next", 0, 0, 0, 0, '0, '0);
    check("wrap_next.pc_const", pc_o, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic        rs, rf, rb, rj;
      logic [31:0] rbt, rjt;
      rs  = ($urandom_range(0, 3) == 0);
      rf  = ($urandom_range(0, 9) == 0);
      rb  = ($urandom_range(0, 9) == 0);
      rj  = ($urandom_range(0, 11) == 0);
      rbt = RST + $urandom_range(0, 40) * 4 + $urandom_range(0, 3);
      rjt = ($urandom_range(0, 7) == 0) ? $urandom : RST + $urandom_range(0, 36) * 4;
      step("rand", rs, rf, rb, rj, rbt, rjt);
    end

    // Asynchronous reset in the middle of a stalled cycle, no clock edge involved.
    step("pre_async", 0, 0, 0, 1, '0, 32'h0040_0020);
    stall = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("async.pc_const", pc_o, 32'h0040_0000);
    check("async.v_const", {31'd0, vld_o}, 32'd0);
    check_all("async");
    @(posedge clk);
    #1;
    check_all("async_hold");
    reset = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 3; i++) step("post_async", 0, 0, 0, 0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of Program_Memory.
- Holds the program counter and selects the next PC (sequential, branch or jump).
- Drives the word address into Program_Memory's Address_i and captures the returned Instruction_o into an IF/ID pipeline register.
- Supports stall, flush and an out-of-range fetch fault for the decode stage and the hazard unit.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction words.
- MEMORY_DEPTH, 32, number of instruction words in Program_Memory; sets the valid fetch range.
- RESET_PC, 32'h0040_0000, byte address of the first instruction; PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall_i  input  1  hazard unit hold request.
- flush_i  input  1  clears the IF/ID register to a bubble.
- branch_taken_i  input  1  redirect PC to branch_target_i.
- branch_target_i  input  DATA_WIDTH  branch byte address.
- jump_i  input  1  redirect PC to jump_target_i.
- jump_target_i  input  DATA_WIDTH  jump byte address.
- instruction_i  input  DATA_WIDTH  word from Program_Memory Instruction_o.
- address_o  output  DATA_WIDTH  word index to Program_Memory Address_i.
- pc_o  output  DATA_WIDTH  current PC, byte address.
- pc_plus4_o  output  DATA_WIDTH  pc_o + 4.
- addr_fault_o  output  1  current PC is outside the instruction memory.
- if_id_instruction_o  output  DATA_WIDTH  registered instruction for decode.
- if_id_pc_plus4_o  output  DATA_WIDTH  registered PC+4 of that instruction.
- if_id_valid_o  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-stall or mid-redirect):
  - pc_o = RESET_PC.
  - if_id_instruction_o = 0 (NOP), if_id_pc_plus4_o = 0, if_id_valid_o = 0.
  - Release is synchronous to the next rising edge; the first fetch uses RESET_PC.
- PC next-state priority on each rising edge: jump_i > branch_taken_i > stall_i (hold) > pc_o+4.
  - A redirect overrides stall_i.
  - Targets have bits [1:0] forced to 0 before loading.
- pc_plus4_o = pc_o + 4, modulo 2^DATA_WIDTH; 32'hFFFF_FFFC wraps to 0.
- Combinational address path:
  - offset = pc_o - RESET_PC.
  - address_o = offset >> 2, zero-extended to DATA_WIDTH.
  - Program_Memory is combinational, so instruction_i is valid in the same cycle; latency from PC to IF/ID is 1 clock.
- addr_fault_o = 1 when pc_o < RESET_PC (unsigned) or (offset >> 2) >= MEMORY_DEPTH. Combinational.
- IF/ID update priority per edge: flush_i (load bubble) > stall_i (hold all three fields) > normal load.
  - Normal load: instruction = instruction_i, pc_plus4 = pc_plus4_o, valid = 1.
  - If addr_fault_o=1, load a bubble instead: NOP, valid = 0, pc_plus4 still captured.
- flush_i with stall_i: IF/ID becomes a bubble; the PC still obeys its own priority (hold if no redirect).
- jump_i and branch_taken_i together: jump wins; the branch is ignored.
- The stage never inserts an automatic flush on redirect; the hazard unit asserts flush_i.
- No state machine beyond the two registers. The PC register is the only state affected by redirects.

Decomposition:
- Shared package fetch_pkg holds:
  - DATA_WIDTH and RESET_PC defaults.
  - NOP_INSTR = 32'h0000_0000.
  - The IF/ID bundle typedef {instruction, pc_plus4, valid}.
- One natural sub-module: pc_register, an enable-gated register with asynchronous active-low reset to RESET_PC.
- The next-PC mux, address translation and IF/ID register live in the top.

Test Plan:
- Reset low for 3 cycles, then released, 4 free-running cycles, ROM word k = 32'h1000_0000+k.
  - pc_o steps 0x00400000, 04, 08, 0C.
  - address_o steps 0, 1, 2, 3.
  - if_id_instruction_o = 0x10000000 one cycle after release, valid = 1.
- stall_i=1 for 2 cycles at PC 0x00400008.
  - pc_o and all IF/ID fields hold.
  - Sequencing resumes at 0x0040000C after stall drops.
- branch_taken_i=1 with target 0x00400040, and again together with jump_i=1, jump target 0x00400010.
  - First case: next pc_o = 0x00400040, address_o = 16.
  - Simultaneous case: pc_o = 0x00400010, jump wins.
- flush_i=1 with stall_i=1.
  - IF/ID becomes NOP, valid = 0, pc_plus4 = 0 path not required.
  - pc_o holds.
- Run to PC 0x00400080 (index 32, MEMORY_DEPTH=32).
  - addr_fault_o = 1.
  - Next IF/ID valid = 0.
  - Jump target 0x00300000 also gives addr_fault_o = 1.
- Assert reset low asynchronously mid-cycle during a stall.
  - pc_o = 0x00400000 and if_id_valid_o = 0 immediately, with no clock edge needed.
